// File: rtl/lvds_tx_pkg.sv
// Shared state encodings, default framing codes and PRBS7 constants for the LVDS transmit framer.
package lvds_tx_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StTrain = 3'd1,
    StReady = 3'd2,
    StSol   = 3'd3,
    StData  = 3'd4,
    StEol   = 3'd5,
    StPrbs  = 3'd6
  } tx_state_e;

  localparam logic [6:0] TrainPatDef = 7'h63;
  localparam logic [6:0] SolCodeDef  = 7'h7E;
  localparam logic [6:0] EolCodeDef  = 7'h01;
  localparam logic [6:0] IdleCodeDef = 7'h00;

  // x^7 + x^6 + 1: feedback from the two oldest bits of the 7-bit window.
  localparam int unsigned Prbs7TapHi = 6;
  localparam int unsigned Prbs7TapLo = 5;
  localparam logic [6:0]  Prbs7Seed  = 7'h7F;

endpackage

// File: rtl/lvds_tx_prbs7.sv
// One-lane PRBS7 step: produces SER_W bits (earliest generated bit in the MSB) and the next state.
module lvds_tx_prbs7
  import lvds_tx_pkg::*;
#(
  parameter int unsigned SER_W = 7
) (
  input  logic [6:0]       lfsr_i,
  output logic [SER_W-1:0] word_o,
  output logic [6:0]       lfsr_o
);

  always_comb begin
    logic [6:0] s;
    logic       b;
    s      = lfsr_i;
    b      = 1'b0;
    word_o = '0;
    for (int unsigned j = 0; j < SER_W; j++) begin
      b                   = s[Prbs7TapHi] ^ s[Prbs7TapLo];
      word_o[SER_W-1-j]   = b;
      s                   = {s[5:0], b};
    end
    lfsr_o = s;
  end

endmodule

// File: rtl/lvds_tx_framer.sv
// Multi-lane LVDS transmit framer: training, SOL/payload/EOL line framing, per-lane inversion.
// Optional PRBS7 link-test mode when LVDS_TX_PRBS_EN is defined.
module lvds_tx_framer
  import lvds_tx_pkg::*;
#(
  parameter int unsigned      LANES       = 4,
  parameter int unsigned      SER_W       = 7,
  parameter int unsigned      LINE_WORDS  = 512,
  parameter int unsigned      TRAIN_WORDS = 64,
  parameter logic [SER_W-1:0] TRAIN_PAT   = SER_W'(TrainPatDef),
  parameter logic [SER_W-1:0] SOL_CODE    = SER_W'(SolCodeDef),
  parameter logic [SER_W-1:0] EOL_CODE    = SER_W'(EolCodeDef),
  parameter logic [SER_W-1:0] IDLE_CODE   = SER_W'(IdleCodeDef)
) (
  input  logic                   gclk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   train_req,
  input  logic [LANES-1:0]       tx_invert,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*SER_W-1:0] s_data,
  input  logic                   s_sol,
`ifdef LVDS_TX_PRBS_EN
  input  logic                   prbs_mode,
`endif
  output logic [LANES*SER_W-1:0] tx_data,
  output logic [2:0]             tx_state,
  output logic [15:0]            line_cnt,
  output logic                   underrun,
  output logic                   drop_err
);

  localparam int unsigned WcW = $clog2(LINE_WORDS + 1);
  localparam int unsigned TcW = $clog2(TRAIN_WORDS + 1);

  tx_state_e              state_q, state_d, tx_state_q;
  logic [WcW-1:0]         word_cnt_q, word_cnt_d;
  logic [TcW-1:0]         train_cnt_q, train_cnt_d;
  logic [15:0]            line_cnt_q, line_cnt_d;
  logic                   underrun_q, underrun_d, drop_err_q, drop_err_d;
  logic                   train_pend_q, train_pend_d, dis_pend_q, dis_pend_d;
  logic [LANES*SER_W-1:0] tx_data_q, word, inv_mask;

`ifdef LVDS_TX_PRBS_EN
  logic [LANES-1:0][6:0]  lfsr_q, lfsr_d, lfsr_nxt;
  logic [LANES*SER_W-1:0] prbs_word;

  for (genvar i = 0; i < LANES; i++) begin : g_prbs
    lvds_tx_prbs7 #(
      .SER_W (SER_W)
    ) u_prbs7 (
      .lfsr_i (lfsr_q[i]),
      .word_o (prbs_word[i*SER_W +: SER_W]),
      .lfsr_o (lfsr_nxt[i])
    );
  end

  // Outside PRBS the generators hold the seed, so entry always starts from 7'h7F.
  always_comb lfsr_d = (state_q == StPrbs) ? lfsr_nxt : {LANES{Prbs7Seed}};

  always_ff @(posedge gclk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= {LANES{Prbs7Seed}};
    else          lfsr_q <= lfsr_d;
  end
`endif

  always_comb begin
    inv_mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      inv_mask[i*SER_W +: SER_W] = {SER_W{tx_invert[i]}};
    end
  end

  always_comb begin
    state_d      = state_q;
    word         = {LANES{IDLE_CODE}};
    train_cnt_d  = '0;
    word_cnt_d   = word_cnt_q;
    line_cnt_d   = line_cnt_q;
    underrun_d   = underrun_q;
    drop_err_d   = drop_err_q;
    train_pend_d = train_pend_q;
    dis_pend_d   = dis_pend_q;
    s_ready      = 1'b0;

    // A started line always completes; requests seen during it wait for READY.
    if (state_q inside {StSol, StData, StEol}) begin
      if (train_req) train_pend_d = 1'b1;
      if (!enable)   dis_pend_d   = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StTrain;
      end
      StTrain: begin
        word        = {LANES{TRAIN_PAT}};
        train_cnt_d = train_cnt_q + TcW'(1);
        if (!enable)                                    state_d = StIdle;
        else if (train_cnt_q == TcW'(TRAIN_WORDS - 1)) state_d = StReady;
      end
      StReady: begin
        s_ready = !s_sol;
        if (s_valid && !s_sol) drop_err_d = 1'b1;
        if (!enable || dis_pend_q) begin
          state_d      = StIdle;
          dis_pend_d   = 1'b0;
          train_pend_d = 1'b0;
        end else if (train_req || train_pend_q) begin
          state_d      = StTrain;
          train_pend_d = 1'b0;
`ifdef LVDS_TX_PRBS_EN
        end else if (prbs_mode) begin
          state_d = StPrbs;
`endif
        end else if (s_valid && s_sol) begin
          state_d    = StSol;
          word_cnt_d = '0;
        end
      end
      StSol: begin
        word    = {LANES{SOL_CODE}};
        state_d = StData;
      end
      StData: begin
        s_ready = 1'b1;
        if (s_valid) begin
          word       = s_data;
          word_cnt_d = word_cnt_q + WcW'(1);
          if (word_cnt_q == WcW'(LINE_WORDS - 1)) state_d = StEol;
        end else begin
          underrun_d = 1'b1;
        end
      end
      StEol: begin
        word       = {LANES{EOL_CODE}};
        line_cnt_d = line_cnt_q + 16'd1;
        state_d    = StReady;
      end
`ifdef LVDS_TX_PRBS_EN
      StPrbs: begin
        word = prbs_word;
        if (!enable)         state_d = StIdle;
        else if (!prbs_mode) state_d = StReady;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge gclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      tx_state_q   <= StIdle;
      tx_data_q    <= '0;
      word_cnt_q   <= '0;
      train_cnt_q  <= '0;
      line_cnt_q   <= '0;
      underrun_q   <= 1'b0;
      drop_err_q   <= 1'b0;
      train_pend_q <= 1'b0;
      dis_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_state_q   <= state_q;
      tx_data_q    <= word ^ inv_mask;
      word_cnt_q   <= word_cnt_d;
      train_cnt_q  <= train_cnt_d;
      line_cnt_q   <= line_cnt_d;
      underrun_q   <= underrun_d;
      drop_err_q   <= drop_err_d;
      train_pend_q <= train_pend_d;
      dis_pend_q   <= dis_pend_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_state = tx_state_q;
  assign line_cnt = line_cnt_q;
  assign underrun = underrun_q;
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Self-checking bench for lvds_tx_framer: line-level behavioural model compared every cycle,
// plus literal expectations. Exercises PRBS mode when LVDS_TX_PRBS_EN is defined.
module tb_lvds_tx_framer;

  localparam int unsigned LANES       = 4;
  localparam int unsigned SER_W       = 7;
  localparam int unsigned LINE_WORDS  = 512;
  localparam int unsigned TRAIN_WORDS = 64;
  localparam int unsigned DW          = LANES * SER_W;
  localparam logic [6:0]  C_TRAIN     = 7'h63;
  localparam logic [6:0]  C_SOL       = 7'h7E;
  localparam logic [6:0]  C_EOL       = 7'h01;
  localparam logic [6:0]  C_IDLE      = 7'h00;
`ifdef LVDS_TX_PRBS_EN
  localparam bit PrbsEn = 1'b1;
`else
  localparam bit PrbsEn = 1'b0;
`endif

  logic             gclk = 1'b0;
  logic             reset_n, enable, train_req, s_valid, s_sol, prbs_mode;
  logic [LANES-1:0] tx_invert;
  logic [DW-1:0]    s_data, tx_data;
  logic             s_ready, underrun, drop_err;
  logic [2:0]       tx_state;
  logic [15:0]      line_cnt;

  always #5 gclk = ~gclk;

  lvds_tx_framer u_dut (
    .gclk      (gclk),
    .reset_n   (reset_n),
    .enable    (enable),
    .train_req (train_req),
    .tx_invert (tx_invert),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sol     (s_sol),
`ifdef LVDS_TX_PRBS_EN
    .prbs_mode (prbs_mode),
`endif
    .tx_data   (tx_data),
    .tx_state  (tx_state),
    .line_cnt  (line_cnt),
    .underrun  (underrun),
    .drop_err  (drop_err)
  );

  int checks = 0;
  int errors = 0;

  // Model state: phase uses the output encodings; counters count down what remains.
  int            m_ph, m_tleft, m_left, m_pidx;
  logic [15:0]   m_line;
  bit            m_under, m_drop, m_ptrain, m_poff;
  logic [DW-1:0] exp_data;
  logic [2:0]    exp_state;
  bit            prbs_seq [0:4095];

  // Observations of the DUT used only by literal expectations.
  logic          last_rdy;
  int            train_run, last_train, data_cyc;
  logic [DW-1:0] sol_word, first_pay, prbs_first;
  bit            first_pend, prbs_seen;

  function automatic logic [DW-1:0] rep(input logic [6:0] c);
    return {LANES{c}};
  endfunction

  function automatic logic [DW-1:0] mask(input logic [LANES-1:0] inv);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i*7 +: 7] = {7{inv[i]}};
    return m;
  endfunction

  function automatic logic [6:0] lane(input logic [DW-1:0] w, input int i);
    return w[i*7 +: 7];
  endfunction

  function automatic logic [DW-1:0] pay(input int k);
    logic [DW-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*7 +: 7] = 7'(k + 32 * i);
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_tleft = 0; m_left = 0; m_pidx = 7; m_line = '0;
    m_under = 0; m_drop = 0; m_ptrain = 0; m_poff = 0;
    exp_data = '0; exp_state = 3'd0;
  endtask

  task automatic model_step();
    logic [DW-1:0] w;
    logic [6:0]    pw;
    int            st_out;
    if (!reset_n) begin
      model_reset();
    end else begin
      w      = rep(C_IDLE);
      st_out = m_ph;
      case (m_ph)
        0: if (enable) begin m_ph = 1; m_tleft = TRAIN_WORDS; end
        1: begin
          w = rep(C_TRAIN);
          m_tleft--;
          if (!enable) m_ph = 0;
          else if (m_tleft == 0) m_ph = 2;
        end
        2: begin
          if (s_valid && !s_sol) m_drop = 1;
          if (!enable || m_poff) begin
            m_ph = 0; m_poff = 0; m_ptrain = 0;
          end else if (train_req || m_ptrain) begin
            m_ph = 1; m_tleft = TRAIN_WORDS; m_ptrain = 0;
          end else if (PrbsEn && prbs_mode) begin
            m_ph = 6; m_pidx = 7;
          end else if (s_valid && s_sol) begin
            m_ph = 3;
          end
        end
        3, 4, 5: begin
          if (train_req) m_ptrain = 1;
          if (!enable)   m_poff   = 1;
          if (m_ph == 3) begin
            w = rep(C_SOL); m_ph = 4; m_left = LINE_WORDS;
          end else if (m_ph == 4) begin
            if (s_valid) begin
              w = s_data;
              m_left--;
              if (m_left == 0) m_ph = 5;
            end else begin
              m_under = 1;
            end
          end else begin
            w = rep(C_EOL); m_line++; m_ph = 2;
          end
        end
        6: begin
          for (int j = 0; j < 7; j++) pw[6-j] = prbs_seq[m_pidx+j];
          m_pidx += 7;
          w = rep(pw);
          if (!enable) m_ph = 0;
          else if (!prbs_mode) m_ph = 2;
        end
        default: m_ph = 0;
      endcase
      exp_data  = w ^ mask(tx_invert);
      exp_state = 3'(st_out);
    end
  endtask

  function automatic logic exp_rdy();
    if (m_ph == 2) return !s_sol;
    return (m_ph == 4);
  endfunction

  task automatic observe();
    if (tx_state == 3'd1) begin
      train_run++;
    end else if (train_run > 0) begin
      last_train = train_run;
      train_run  = 0;
    end
    if (tx_state == 3'd3) begin
      data_cyc = 0; sol_word = tx_data; first_pend = 1;
    end
    if (tx_state == 3'd4) begin
      if (first_pend) begin first_pay = tx_data; first_pend = 0; end
      data_cyc++;
    end
    if (tx_state == 3'd6 && !prbs_seen) begin prbs_first = tx_data; prbs_seen = 1; end
  endtask

  // One cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge gclk);
    chk("tx_data", 32'(tx_data), 32'(exp_data));
    chk("tx_state", 32'(tx_state), 32'(exp_state));
    chk("s_ready", 32'(s_ready), 32'(exp_rdy()));
    chk("line_cnt", 32'(line_cnt), 32'(m_line));
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("drop_err", 32'(drop_err), 32'(m_drop));
    observe();
    last_rdy = s_ready;
    @(posedge gclk);
    model_step();
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int n = 0;
    while (tx_state != st && n < budget) begin tick(); n++; end
    chk("reach_state", 32'(tx_state), 32'(st));
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit sol, input bit pulse);
    int n = 0;
    s_valid = 1'b1; s_sol = sol; s_data = d; train_req = pulse;
    do begin
      tick();
      train_req = 1'b0;
      n++;
    end while (!last_rdy && n < 64);
    checks++;
    if (!last_rdy) begin
      errors++;
      $display("FAIL send_word: not accepted after %0d cycles, required accept", n);
    end
    s_sol = 1'b0;
  endtask

  task automatic send_line(input int gap_at, input int gap_len, input int train_at);
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (k == gap_at) begin
        s_valid = 1'b0;
        repeat (gap_len) tick();
      end
      send_word(pay(k), k == 0, k == train_at);
    end
    s_valid = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    chk({tag, "_tx_state"}, 32'(tx_state), 32'h0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'h0);
    chk({tag, "_line_cnt"}, 32'(line_cnt), 32'h0);
    chk({tag, "_flags"}, 32'({underrun, drop_err}), 32'h0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 7; n++) prbs_seq[n] = 1'b1;
    for (int n = 7; n < 4096; n++) prbs_seq[n] = prbs_seq[n-6] ^ prbs_seq[n-7];
    train_run = 0; last_train = 0; data_cyc = 0; first_pend = 0; prbs_seen = 0;
    sol_word = '0; first_pay = '0; prbs_first = '0; last_rdy = 1'b0;
    reset_n = 1'b0; enable = 1'b0; train_req = 1'b0; s_valid = 1'b0; s_sol = 1'b0;
    s_data = '0; tx_invert = '0; prbs_mode = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_tx_state", 32'(tx_state), 32'h0);
    chk("rst_s_ready", 32'(s_ready), 32'h0);

    // Training after enable.
    reset_n = 1'b1;
    enable  = 1'b1;
    wait_state(3'd2, 200);
    tick();
    chk("train_len", 32'(last_train), 32'd64);
    chk("ready_word", 32'(tx_data), 32'h0);

    // Clean line.
    send_line(-1, 0, -1);
    wait_state(3'd2, 20);
    chk("l1_line_cnt", 32'(line_cnt), 32'd1);
    chk("l1_underrun", 32'(underrun), 32'd0);
    chk("l1_drop_err", 32'(drop_err), 32'd0);
    chk("l1_payload_cycles", 32'(data_cyc), 32'd512);
    chk("l1_sol_word", 32'(sol_word), 32'(rep(7'h7E)));
    chk("l1_first_pay", 32'(first_pay), 32'(pay(0)));

    // Line with a three-cycle underrun gap.
    send_line(200, 3, -1);
    wait_state(3'd2, 20);
    chk("l2_line_cnt", 32'(line_cnt), 32'd2);
    chk("l2_underrun", 32'(underrun), 32'd1);
    chk("l2_data_cycles", 32'(data_cyc), 32'd515);

    // Lane 1 inverted.
    tx_invert = 4'b0010;
    send_line(-1, 0, -1);
    wait_state(3'd2, 20);
    chk("l3_sol_lane1", 32'(lane(sol_word, 1)), 32'h01);
    chk("l3_sol_lane0", 32'(lane(sol_word, 0)), 32'h7E);
    chk("l3_pay_lane1", 32'(lane(first_pay, 1)), 32'h5F);
    chk("l3_pay_lane2", 32'(lane(first_pay, 2)), 32'h40);
    tx_invert = 4'b0000;

    // Training request mid-line: line completes, then a full burst.
    send_line(-1, 0, 100);
    wait_state(3'd2, 20);
    chk("l4_line_cnt", 32'(line_cnt), 32'd4);
    wait_state(3'd1, 5);
    wait_state(3'd2, 200);
    tick();
    chk("l4_train_len", 32'(last_train), 32'd64);

    // Non-SOL word in READY is dropped.
    s_valid = 1'b1; s_sol = 1'b0; s_data = pay(7);
    tick();
    s_valid = 1'b0;
    tick();
    chk("drop_err_set", 32'(drop_err), 32'd1);

    // Disable from READY.
    enable = 1'b0;
    repeat (2) tick();
    chk("disable_idle", 32'(tx_state), 32'd0);
    enable = 1'b1;
    wait_state(3'd2, 200);

`ifdef LVDS_TX_PRBS_EN
    prbs_mode = 1'b1;
    repeat (20) tick();
    chk("prbs_first_lane0", 32'(lane(prbs_first, 0)), 32'h01);
    chk("prbs_first_lane3", 32'(lane(prbs_first, 3)), 32'h01);
    prbs_mode = 1'b0;
    wait_state(3'd2, 5);
    prbs_mode = 1'b1;
    repeat (6) tick();
    reset_check("prbs_rst");
    prbs_mode = 1'b0;
    reset_n = 1'b1;
    wait_state(3'd2, 200);
`endif

    // Reset in the middle of a line.
    s_valid = 1'b1; s_sol = 1'b1; s_data = pay(0);
    repeat (10) tick();
    reset_check("line_rst");
    s_valid = 1'b0; s_sol = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvds_tx_framer.md
# lvds_tx_framer

Parametrised multi-lane LVDS transmit framer in the `gclk` (parallel-word) domain, sitting between the image pipeline and the per-lane 7:1 serializer wrappers. Each cycle it drives one SER_W-bit word per lane. The word is a link-training pattern, a line-framing code (SOL/EOL/IDLE) or pixel payload, accepted over a valid/ready stream. Per-lane polarity inversion generalises the single-lane swap of the previous serializer generation, and an optional PRBS7 link-test mode is available.

## Interface
- LANES, 4: number of serial lanes.
- SER_W, 7: bits per lane per `gclk` cycle; bit SER_W-1 is first on the wire.
- LINE_WORDS, 512: payload words per lane per line (≥1).
- TRAIN_WORDS, 64: training cycles per training burst (≥1).
- TRAIN_PAT, 7'h63: training word, all lanes.
- SOL_CODE, 7'h7E / EOL_CODE, 7'h01 / IDLE_CODE, 7'h00: framing words, all lanes.
- gclk  in  1  word clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  link enable (level).
- train_req  in  1  single-cycle request for a training burst.
- tx_invert  in  LANES  per-lane polarity: lane i output is XORed with {SER_W{tx_invert[i]}}.
- s_valid  in  1  payload word valid.
- s_ready  out  1  payload word accepted when s_valid&s_ready.
- s_data  in  LANES*SER_W  payload; lane i = bits [i*SER_W +: SER_W].
- s_sol  in  1  marks the first word of a line (qualified by s_valid).
- tx_data  out  LANES*SER_W  registered word to serializers.
- tx_state  out  3  current state encoding.
- line_cnt  out  16  completed lines since reset, wraps 0xFFFF→0.
- underrun  out  1  sticky: s_valid low in DATA.
- drop_err  out  1  sticky: non-SOL word discarded in READY.
- prbs_mode  in  1  only present with LVDS_TX_PRBS_EN.

## Operation
- States and encodings: IDLE=0, TRAIN=1, READY=2, SOL=3, DATA=4, EOL=5, PRBS=6.
- Words emitted per state:
  - IDLE: IDLE_CODE, s_ready=0. enable=1 → TRAIN.
  - TRAIN: TRAIN_PAT for exactly TRAIN_WORDS cycles, s_ready=0, then → READY. enable=0 aborts to IDLE next cycle.
  - READY: IDLE_CODE.
    - s_ready = !s_sol. Non-SOL valid words are consumed, discarded and set drop_err.
    - s_valid&s_sol → SOL; that word is not consumed.
    - Priority: enable=0 → IDLE; else train_req (or pending) → TRAIN; else SOL.
  - SOL: SOL_CODE for one cycle, s_ready=0 → DATA.
  - DATA: s_ready=1.
    - Each accepted word appears on tx_data the next cycle and increments the word counter. s_sol inside DATA is ignored (treated as payload).
    - A cycle with s_valid=0 emits IDLE_CODE, sets underrun and does not advance the counter.
    - After LINE_WORDS accepted → EOL; s_ready is 0 in the cycle after the last accept.
  - EOL: EOL_CODE for one cycle, line_cnt+1 → READY.
- train_req or enable=0 arriving in SOL/DATA/EOL is latched as pending and acted on in READY; the line always completes.
- tx_invert is applied in the output register to every word type. Changes take effect on the next tx_data update.
- underrun/drop_err clear only on reset.

## Timing
- Reset values: state IDLE, tx_data all lanes IDLE_CODE^invert-free 0 (all zeros), s_ready 0, line_cnt 0, underrun 0, drop_err 0, pending flags 0.
- Latency: s_data accepted at edge N → tx_data at edge N+1.
- tx_state is registered and aligned with the word on tx_data.
- Line on tx_data: SOL, LINE_WORDS payload (plus IDLE gap cycles on underrun), EOL.
- Minimum line-to-line gap: one READY cycle.
- Word counter width: $clog2(LINE_WORDS+1); cleared on entry to SOL.
- Reset asserted mid-line: immediate return to reset values; no EOL is emitted.

## Configuration
- LVDS_TX_PRBS_EN defined:
  - prbs_mode port exists. In READY with prbs_mode=1 (priority after enable/train), the framer enters PRBS.
  - PRBS: each lane runs an independent PRBS7 (x^7+x^6+1), seeded 7'h7F on entry, advancing SER_W bits per cycle. The MSB is the earliest generated bit. Inversion still applies.
  - prbs_mode=0 → READY; enable=0 → IDLE.
- Not defined: no prbs_mode port, no generator logic, encoding 6 unreachable.

## Structure
- Package lvds_tx_pkg:
  - state encodings;
  - default TRAIN/SOL/EOL/IDLE codes;
  - PRBS7 tap constants.
- Sub-module lvds_tx_prbs7 (one instance per lane, SER_W-bit parallel step), instantiated only under LVDS_TX_PRBS_EN.

## Test plan
- Reset release, enable=1 → 64 cycles of 0x63 on all 4 lanes, then tx_state=2 with tx_data all 0x00.
- READY, s_valid=1, s_sol=1, 512 incrementing words → 0x7E, 512 words each one cycle after accept, 0x01, line_cnt=1, underrun=0.
- s_valid dropped for 3 cycles mid-line → 3 IDLE words inserted, line still exactly 512 payload words, underrun=1.
- tx_invert=4'b0010 during line → only lane 1 bitwise inverted (SOL reads 0x01 on lane 1), others unchanged.
- train_req pulsed at word 100 of a line → line completes with EOL, then 64-cycle training, then READY; non-SOL word in READY sets drop_err.
- With LVDS_TX_PRBS_EN, prbs_mode=1 in READY → lane sequence matches PRBS7 reference from seed 0x7F. prbs_mode=0 → READY; reset mid-PRBS → IDLE with zeros.
